// File: rtl/serial_sub_add.sv
// serial_sub_add: multi-cycle digit-serial adder/subtractor.
//   Computes A+B+B_CIN (SUB_ADD=0) or A-B-B_CIN (SUB_ADD=1) on WIDTH-bit
//   operands. Each RUN cycle handles one DIGIT-bit slice, LSB slice first,
//   so the result takes N = WIDTH/DIGIT cycles after the accepted start.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            request, only sampled in IDLE
//   SUB_ADD, A, B, B_CIN  operation and operands, latched at accepted start
//   busy             high while an operation is running
//   done             one-cycle pulse when D_S/B_COUT/OVF update
//   D_S, B_COUT, OVF result, raw carry/borrow out, signed overflow (held)
// Optional: define SERIAL_SUB_ADD_SAT_EN to saturate D_S on signed overflow.
module serial_sub_add #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             SUB_ADD,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_CIN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D_S,
    output logic             B_COUT,
    output logic             OVF
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             sub_q, sub_d, chain_q, chain_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_s_q, d_s_d;
    logic             b_cout_q, b_cout_d, ovf_q, ovf_d, done_q, done_d;

    // One slice step; the extra top bit is the carry (add) or borrow (sub),
    // since a negative difference wraps to have bit DIGIT set.
    logic [DIGIT:0]   slice_w;
    logic [WIDTH-1:0] res_next;
    logic             res_msb, ovf_w;

    always_comb begin
        slice_w = '0;
        if (sub_q)
            slice_w = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                      - {{DIGIT{1'b0}}, chain_q};
        else
            slice_w = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, chain_q};
        // New slice enters at the top; after N steps slice 0 sits at bit 0.
        res_next = (res_q >> DIGIT) | (WIDTH'(slice_w[DIGIT-1:0]) << (WIDTH - DIGIT));
        res_msb  = res_next[WIDTH-1];
        // Operand MSBs are kept aside because the operand registers shift.
        if (sub_q)
            ovf_w = (a_msb_q != b_msb_q) && (res_msb != a_msb_q);
        else
            ovf_w = (a_msb_q == b_msb_q) && (res_msb != a_msb_q);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        sub_d    = sub_q;
        chain_d  = chain_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        cnt_d    = cnt_q;
        d_s_d    = d_s_q;
        b_cout_d = b_cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sub_d   = SUB_ADD;
                    chain_d = B_CIN;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                chain_d = slice_w[DIGIT];
                res_d   = res_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    b_cout_d = slice_w[DIGIT];
                    ovf_d    = ovf_w;
`ifdef SERIAL_SUB_ADD_SAT_EN
                    if (ovf_w)
                        d_s_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
                    else
                        d_s_d = res_next;
`else
                    d_s_d = res_next;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            sub_q    <= 1'b0;
            chain_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            cnt_q    <= '0;
            d_s_q    <= '0;
            b_cout_q <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            sub_q    <= sub_d;
            chain_q  <= chain_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            cnt_q    <= cnt_d;
            d_s_q    <= d_s_d;
            b_cout_q <= b_cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign D_S    = d_s_q;
    assign B_COUT = b_cout_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_serial_sub_add.sv
module tb_serial_sub_add;

    logic       clk = 1'b0;
    logic       rst, start, sub_add, b_cin;
    logic [7:0] a, b;
    logic       busy, done, b_cout, ovf;
    logic [7:0] d_s;

    int total = 0;
    int bad   = 0;

    // Observations from the last run_op call
    int lat, busy_cnt;

    serial_sub_add #(.WIDTH(8), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .SUB_ADD(sub_add),
        .A(a), .B(b), .B_CIN(b_cin),
        .busy(busy), .done(done), .D_S(d_s), .B_COUT(b_cout), .OVF(ovf)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge.
    // Issues one operation and waits (bounded) for done; lat=-1 on timeout.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          input logic icin, input logic isub);
        @(negedge clk);
        a = ia; b = ib; b_cin = icin; sub_add = isub; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        if (busy) busy_cnt++;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin lat = i; break; end
            if (busy) busy_cnt++;
        end
        if (lat == 0) lat = -1;
        // done cycle itself must not be busy
        if (busy) busy_cnt = busy_cnt + 100;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sub_add = 1'b0; b_cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if ({busy, done, b_cout, ovf} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, b_cout, ovf}); end
        total++; if (d_s !== 8'h00) begin bad++; $display("FAIL reset_ds got=%h exp=00", d_s); end
        rst = 1'b0;
    endtask

    task automatic test_add;
        run_op(8'h3C, 8'h0F, 1'b0, 1'b0);
        total++; if (lat !== 2) begin bad++; $display("FAIL add_latency got=%0d exp=2", lat); end
        total++; if (busy_cnt !== 2) begin bad++; $display("FAIL add_busy_cycles got=%0d exp=2", busy_cnt); end
        total++; if (d_s !== 8'h4B) begin bad++; $display("FAIL add_ds got=%h exp=4b", d_s); end
        total++; if ({b_cout, ovf} !== 2'b00) begin bad++; $display("FAIL add_flags got=%b exp=00", {b_cout, ovf}); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b exp=0", done); end
        total++; if (d_s !== 8'h4B) begin bad++; $display("FAIL add_ds_hold got=%h exp=4b", d_s); end
    endtask

    task automatic test_carry_chain;
        run_op(8'hFF, 8'h00, 1'b1, 1'b0);
        total++; if (d_s !== 8'h00) begin bad++; $display("FAIL carry_ds got=%h exp=00", d_s); end
        total++; if ({b_cout, ovf} !== 2'b10) begin bad++; $display("FAIL carry_flags got=%b exp=10", {b_cout, ovf}); end
        run_op(8'h10, 8'h20, 1'b0, 1'b1);
        total++; if (d_s !== 8'hF0) begin bad++; $display("FAIL borrow_ds got=%h exp=f0", d_s); end
        total++; if ({b_cout, ovf} !== 2'b10) begin bad++; $display("FAIL borrow_flags got=%b exp=10", {b_cout, ovf}); end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_pos, exp_neg;
`ifdef SERIAL_SUB_ADD_SAT_EN
        exp_pos = 8'h7F; exp_neg = 8'h80;
`else
        exp_pos = 8'h80; exp_neg = 8'h7F;
`endif
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        total++; if (d_s !== exp_pos) begin bad++; $display("FAIL ovf_add_ds got=%h exp=%h", d_s, exp_pos); end
        total++; if ({b_cout, ovf} !== 2'b01) begin bad++; $display("FAIL ovf_add_flags got=%b exp=01", {b_cout, ovf}); end
        run_op(8'h80, 8'h01, 1'b0, 1'b1);
        total++; if (d_s !== exp_neg) begin bad++; $display("FAIL ovf_sub_ds got=%h exp=%h", d_s, exp_neg); end
        total++; if ({b_cout, ovf} !== 2'b01) begin bad++; $display("FAIL ovf_sub_flags got=%b exp=01", {b_cout, ovf}); end
    endtask

    task automatic test_start_while_busy;
        @(negedge clk);
        a = 8'h12; b = 8'h34; b_cin = 1'b0; sub_add = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; b_cin = 1'b1; sub_add = 1'b1;  // start stays high
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b exp=1", busy); end
        @(posedge clk);
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL hold_early_done got=%b exp=0", done); end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL hold_done got=%b exp=1", done); end
        total++; if (d_s !== 8'h46) begin bad++; $display("FAIL hold_ds got=%h exp=46", d_s); end
        @(posedge clk);
        @(negedge clk);
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL hold_idle got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_back_to_back;
        run_op(8'h11, 8'h22, 1'b0, 1'b0);
        total++; if (d_s !== 8'h33) begin bad++; $display("FAIL b2b_first_ds got=%h exp=33", d_s); end
        // Still in the done cycle: request the next operation now.
        a = 8'h50; b = 8'h20; b_cin = 1'b0; sub_add = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_accept got=%b exp=10", {busy, done}); end
        @(posedge clk);
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_early_done got=%b exp=0", done); end
        @(posedge clk);
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done); end
        total++; if (d_s !== 8'h30) begin bad++; $display("FAIL b2b_second_ds got=%h exp=30", d_s); end
    endtask

    task automatic test_reset_mid_run;
        int seen_done;
        @(negedge clk);
        a = 8'h3C; b = 8'h0F; b_cin = 1'b0; sub_add = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++; if ({busy, done, b_cout, ovf} !== 4'b0000) begin bad++; $display("FAIL abort_flags got=%b exp=0000", {busy, done, b_cout, ovf}); end
        total++; if (d_s !== 8'h00) begin bad++; $display("FAIL abort_ds got=%h exp=00", d_s); end
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        total++; if (seen_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
        run_op(8'h05, 8'h03, 1'b1, 1'b1);
        total++; if (lat !== 2) begin bad++; $display("FAIL after_abort_latency got=%0d exp=2", lat); end
        total++; if (d_s !== 8'h01) begin bad++; $display("FAIL after_abort_ds got=%h exp=01", d_s); end
        total++; if ({b_cout, ovf} !== 2'b00) begin bad++; $display("FAIL after_abort_flags got=%b exp=00", {b_cout, ovf}); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_carry_chain;
        test_overflow;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_run;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
